stream_burst_source: RTL and testbench

Command-driven valid/ready stream producer. It accepts a burst command (base, stride, length) and emits `len` data beats on a valid/ready output port, one beat per cycle under no backpressure. It holds every beat stable under backpressure and signals completion with a one-cycle `done` pulse. It is the transmitting end that feeds the team's registered valid/ready pipeline stages, for datapath bring-up and DMA-style pattern generation.

---
 rtl/stream_burst_pkg.sv | 9 +
 rtl/stream_burst_source.sv | 83 ++++++++
 tb/tb_stream_burst_source.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stream_burst_pkg.sv
// Shared types and default widths for the burst pattern source.
package stream_burst_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, BURST, DONE} burst_state_t;

endpackage

// File: rtl/stream_burst_source.sv
// Command-driven valid/ready producer: emits len beats base, base+stride, ...
// then pulses done for one cycle before accepting the next command.
module stream_burst_source
  import stream_burst_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_base,
  input  logic [WIDTH-1:0] cmd_stride,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  burst_state_t     r_state;
  burst_state_t     w_state_next;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_stride;
  logic [CNT_W-1:0] r_remain;
  logic             w_accept;
  logic             w_fire;
  logic             w_is_last;

  assign w_is_last = (r_remain == CNT_W'(1));
  assign w_accept  = (r_state == IDLE) && cmd_valid;
  assign w_fire    = (r_state == BURST) && out_ready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_state_next = (cmd_len == '0) ? DONE : BURST;
        end
      end
      BURST: begin
        if (out_ready && w_is_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_stride <= '0;
      r_remain <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_data   <= cmd_base;
        r_stride <= cmd_stride;
        r_remain <= cmd_len;
      end else if (w_fire) begin
        // Modulo 2^WIDTH wrap of the pattern is intentional.
        r_data   <= r_data + r_stride;
        r_remain <= r_remain - CNT_W'(1);
      end
    end
  end

  // All stream outputs derive from registered state only, never from out_ready.
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign out_valid = (r_state == BURST);
  assign out_data  = r_data;
  assign out_last  = (r_state == BURST) && w_is_last;

endmodule

// File: tb/tb_stream_burst_source.sv
// Randomised scoreboard bench for stream_burst_source with a cycle-level
// reference model built from beat lists (base + i*stride) and event timing.
module tb_stream_burst_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_base = '0;
  logic [31:0] cmd_stride = '0;
  logic [15:0] cmd_len = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  stream_burst_source #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready: 0 = always ready, 1 = random, 2 = fixed stall pattern
  int rdy_mode = 0;
  int pidx = 0;
  bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'($urandom_range(0, 1));
      2: begin
        out_ready = (pidx < 8) ? pat[pidx] : 1'b1;
        pidx++;
      end
      default: out_ready = 1'b1;
    endcase
  end

  // Reference model: beats expected, burst-in-progress flag, cycle of done
  logic [31:0] q_data[$];
  bit          q_last[$];
  bit          m_active = 0;
  int          m_done_cyc = -1;
  int          cyc = 0;
  int          pops = 0;

  always @(negedge clk) begin
    bit idle, exp_v, exp_done;
    cyc++;
    if (!rst_n) begin
      chk("reset_outs", {cmd_ready, busy, out_valid, done, out_last, out_data},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      m_active = 0;
      m_done_cyc = -1;
      q_data.delete();
      q_last.delete();
    end else begin
      idle     = !m_active;
      exp_v    = m_active && (q_data.size() > 0);
      exp_done = m_active && (cyc == m_done_cyc);
      chk("ctl{rdy,busy,vld,done}", {cmd_ready, busy, out_valid, done},
          {idle, !idle, exp_v, exp_done});
      if (exp_v) begin
        chk("beat{last,data}", {out_last, out_data}, {q_last[0], q_data[0]});
        if (out_ready) begin
          void'(q_data.pop_front());
          void'(q_last.pop_front());
          pops++;
          if (q_data.size() == 0) m_done_cyc = cyc + 1;
        end
      end
      if (exp_done) m_active = 0;
      if (idle && cmd_valid) begin
        for (int i = 0; i < int'(cmd_len); i++) begin
          q_data.push_back(cmd_base + cmd_stride * 32'(i));
          q_last.push_back(i == int'(cmd_len) - 1);
        end
        m_active = 1;
        m_done_cyc = (cmd_len == 0) ? cyc + 1 : -1;
        $display("cmd accepted: base=%h stride=%h len=%0d", cmd_base, cmd_stride, cmd_len);
      end
    end
  end

  task automatic send_cmd(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
    int t;
    cmd_base = b;
    cmd_stride = s;
    cmd_len = l;
    cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 100);
    if (!cmd_ready) chk("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((m_active || q_data.size() != 0) && t < 400);
    if (m_active) chk("idle_timeout", 64'(m_active), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst
    rdy_mode = 0;
    send_cmd(32'h100, 32'd4, 16'd4);
    wait_idle();

    // Backpressure pattern
    pidx = 0;
    rdy_mode = 2;
    send_cmd(32'h100, 32'd4, 16'd4);
    wait_idle();
    rdy_mode = 0;

    // Boundaries
    send_cmd(32'h55, 32'd1, 16'd0);
    wait_idle();
    send_cmd(32'hABCD_0000, 32'd3, 16'd1);
    wait_idle();

    // Wrap-around and constant pattern
    send_cmd(32'hFFFF_FFF8, 32'd8, 16'd3);
    wait_idle();
    send_cmd(32'h1234_5678, 32'd0, 16'd3);
    wait_idle();

    // Second command offered while the first burst is running
    send_cmd(32'h2000, 32'd16, 16'd5);
    send_cmd(32'h3000, 32'd1, 16'd3);
    wait_idle();

    // Reset after two of eight beats
    p0 = pops;
    send_cmd(32'h4000, 32'd2, 16'd8);
    for (int t = 0; t < 50 && pops < p0 + 2; t++) @(negedge clk);
    chk("beats_before_reset", 64'(pops - p0), 64'd2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", {cmd_ready, busy, out_valid, done, out_last, out_data},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_cmd(32'h5000, 32'd7, 16'd3);
    wait_idle();

    // Random commands under random backpressure
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      send_cmd($urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom,
               16'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
